// File: rtl/dec_scan_n_pkg.sv
// Shared types and helpers for the registered one-hot decoder family.
package dec_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIRECT,
      SCAN
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int unsigned ONEHOT_MAX_N = 8;

   // Decodes up to ONEHOT_MAX_N select bits; callers keep the low 2^N bits.
   function automatic logic [2**ONEHOT_MAX_N-1:0] onehot(input logic [ONEHOT_MAX_N-1:0] sel);
      onehot      = '0;
      onehot[sel] = 1'b1;
   endfunction

endpackage

// File: rtl/dec_onehot_n.sv
// Combinational N-to-2^N one-hot decode with enable; all-zero when disabled.
module dec_onehot_n #(
   parameter int unsigned N = 3
) (
   input  logic           en,
   input  logic [N-1:0]   sel,
   output logic [2**N-1:0] y
);

   localparam int unsigned OUT_W = 2**N;

   always_comb begin
      y = '0;
      for (int unsigned i = 0; i < OUT_W; i++) begin
         y[i] = en && (sel == N'(i));
      end
   end

endmodule

// File: rtl/dec_scan_n.sv
// Registered one-hot decoder with a direct-select mode and a dwell-timed scan sequencer.
module dec_scan_n
   import dec_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               mode,
   input  logic [N-1:0]       sel,
   input  logic               sel_vld,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [N-1:0]       last,
   output logic [2**N-1:0]    y,
   output logic [N-1:0]       idx,
   output logic               wrap
);

   localparam int unsigned OUT_W = 2**N;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   y_q, y_d;
   logic [N-1:0]       idx_q, idx_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [N-1:0]       last_q, last_d;
   logic               y_on;

   // y is always rebuilt from the next index, so y[idx] holds whenever y is non-zero.
   dec_onehot_n #(.N(N)) u_onehot (
      .en  (y_on),
      .sel (idx_d),
      .y   (y_d)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      last_d  = last_q;
      y_on    = |y_q;

      if (!en) begin
         state_d = IDLE;
         y_on    = 1'b0;
         cnt_d   = '0;
      end else if (state_q != SCAN && mode == MODE_SCAN) begin
         state_d = SCAN;
         idx_d   = '0;
         y_on    = 1'b1;
         cnt_d   = '0;
         dwell_d = dwell;
         last_d  = last;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = DIRECT;
               y_on    = 1'b0;
            end
            DIRECT: begin
               if (sel_vld) begin
                  idx_d = sel;
                  y_on  = 1'b1;
               end
            end
            SCAN: begin
               if (mode == MODE_DIRECT) begin
                  state_d = DIRECT;
                  y_on    = 1'b0;
                  cnt_d   = '0;
               end else begin
                  y_on = 1'b1;
                  if (cnt_q != dwell_q) begin
                     cnt_d = cnt_q + DWELL_W'(1);
                  end else begin
                     cnt_d = '0;
                     if (idx_q == last_q) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                     end else begin
                        idx_d = idx_q + N'(1);
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
               y_on    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
         dwell_q <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         last_q  <= last_d;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: doc/dec_scan_n.md
Name: dec_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable. It has two modes:
  - Direct mode: registered decode of an input select.
  - Scan mode: an internal sequencer steps the active output through 0..last, holding each output for a programmable dwell.
- Intended for row/column strobing and chip-select fan-out, in place of fixed-width combinational decoders.

Parameters:
- N, 3, select width; output width is 2^N (derived localparam OUT_W).
- DWELL_W, 8, width of the dwell-count input and internal dwell counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; 0 forces outputs low.
- mode  input  1  0 = direct, 1 = scan.
- sel  input  N  direct-mode select.
- sel_vld  input  1  qualifies sel in direct mode.
- dwell  input  DWELL_W  scan hold time, in cycles minus one.
- last  input  N  highest index visited in scan.
- y  output  2^N  registered one-hot (or all-zero) output.
- idx  output  N  index currently driven on y.
- wrap  output  1  one-cycle pulse when scan returns to index 0.

Behaviour:
- Reset (async, rst=1):
  - y=0, idx=0, wrap=0, state=IDLE.
  - Dwell counter, dwell_q and last_q are cleared to 0.
  - Takes effect immediately and overrides everything, including mid-scan.
- States: IDLE, DIRECT, SCAN. All transitions happen on rising clk.
- y is always zero or exactly one-hot, and y[idx]=1 whenever y!=0.
- Priority: rst > en > mode.
- en=0 in any state: next edge y=0, wrap=0, state=IDLE; idx holds its last value.
- IDLE, en=1:
  - mode=0 -> DIRECT, with y=0 until the first sel_vld.
  - mode=1 -> SCAN entry (see below).
- DIRECT (en=1, mode=0):
  - On sel_vld=1: next edge y=1<<sel and idx=sel (latency 1 cycle).
  - Without sel_vld: y and idx hold.
  - Back-to-back sel_vld updates every cycle.
  - wrap stays 0.
- SCAN entry (from IDLE or DIRECT, with mode=1):
  - Next edge: y=1 (index 0), idx=0, cnt=0.
  - dwell_q<=dwell and last_q<=last. These are latched once; changes mid-scan are ignored until the next entry.
  - wrap=0 on the entry cycle.
- SCAN steady, each cycle:
  - If cnt!=dwell_q: cnt++.
  - Else cnt<=0, and:
    - if idx==last_q: idx<=0, y<=1, wrap<=1;
    - otherwise idx<=idx+1, y<=y<<1.
  - wrap is high only in the cycle where y first shows index 0 after a wrap.
- SCAN boundaries:
  - dwell_q=0: advances every cycle.
  - last_q=0: y stays at bit 0; wrap pulses every dwell_q+1 cycles.
  - last_q=2^N-1: full sweep; idx wraps naturally with no overflow past OUT_W.
- SCAN -> DIRECT (mode falls, en=1): next edge y=0, cnt=0, wrap=0, state=DIRECT. idx holds until sel_vld.
- sel_vld is ignored in SCAN and IDLE.
- sel_vld in the same cycle as mode 0->1: SCAN entry wins; sel is ignored.
- All arithmetic is unsigned. cnt is DWELL_W bits and never exceeds dwell_q.

Decomposition:
- Shared package dec_pkg:
  - State enum typedef (IDLE, DIRECT, SCAN).
  - Function onehot(sel) returning a 2^N-bit vector.
  - Mode encoding constants MODE_DIRECT=0, MODE_SCAN=1.
- One natural combinational sub-module: dec_onehot_n. Parameter N; inputs en and sel[N-1:0]; output 2^N one-hot. It replaces the fixed 3x8 dataflow decode and feeds the y register next-state.

Test Plan:
- Reset: pulse rst mid-scan with N=3, dwell=2, last=5 -> y=0, idx=0 and wrap=0 immediately, before the next clk edge.
- Direct decode: en=1, mode=0, sel=5, sel_vld=1 for 1 cycle -> next edge y=8'b0010_0000, idx=5, held until sel_vld with sel=2 gives y=8'b0000_0100.
- Scan sweep: en=1, mode=1, dwell=1, last=3 -> y sequence 01,01,02,02,04,04,08,08,01…; wrap=1 only on the first 01 after each 08 (period 8 cycles).
- Edge config: dwell=0, last=7 -> y shifts every cycle through 8 bits, wrap every 8 cycles. Then re-enter with dwell=3, last=0 -> y=01 constant, wrap every 4 cycles.
- Latched config: during scan change dwell 1->5 and last 3->7 -> sequence unchanged; after mode 1->0->1 the new values apply.
- Priority: en=0 while mode=1 and sel_vld=1 -> y=0, wrap=0 next edge, idx held. en=1 with sel_vld in SCAN -> no effect on y.
